// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's instruction-memory, redirect and decode-side signals.
// master = fetch unit, slave = memory/execute/decode environment.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_pc_plus4;

   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues pipelined imem requests,
// queues returned instructions in order and flushes/discards on redirect.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & ~XLEN'(3);

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_q_pc    [DEPTH];
   logic [XLEN-1:0] r_q_instr [DEPTH];
   logic [XLEN-1:0] r_pf      [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW-1:0]   r_pf_wr;
   logic [AW-1:0]   r_pf_rd;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   r_inflight;
   logic [CW-1:0]   r_drop;

   logic [CW:0]     w_credit_q;
   logic [CW:0]     w_credit_pf;
   logic            w_req_valid;
   logic            w_issue;
   logic            w_rsp;
   logic            w_rsp_drop;
   logic            w_push;
   logic            w_out_valid;
   logic            w_pop;
   logic            w_unused;

   // Queue credit counts in-flight requests; the pc FIFO must also hold addresses
   // of responses still to be dropped.
   assign w_credit_q  = {1'b0, r_count}    + {1'b0, r_inflight};
   assign w_credit_pf = {1'b0, r_inflight} + {1'b0, r_drop};
   assign w_req_valid = !reset && !bus.redirect_valid &&
                        (w_credit_q  < (CW+1)'(DEPTH)) &&
                        (w_credit_pf < (CW+1)'(DEPTH));
   assign w_issue     = w_req_valid && bus.imem_req_ready;
   assign w_rsp       = bus.imem_rsp_valid;
   assign w_rsp_drop  = w_rsp && (r_drop != '0);
   assign w_push      = w_rsp && (r_drop == '0) && !bus.redirect_valid;
   assign w_out_valid = (r_count != '0);
   assign w_pop       = w_out_valid && bus.out_ready && !bus.redirect_valid;
   assign w_unused    = ^bus.redirect_pc[1:0];

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_fetch_pc;
   assign bus.out_valid      = w_out_valid;
   assign bus.out_instr      = r_q_instr[r_rd_ptr];
   assign bus.out_pc         = r_q_pc[r_rd_ptr];
   assign bus.out_pc_plus4   = r_q_pc[r_rd_ptr] + XLEN'(4);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC_ALIGNED;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pf_wr    <= '0;
         r_pf_rd    <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop     <= '0;
      end else begin
         if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
            r_pf_wr    <= r_pf_wr + AW'(1);
         end
         if (w_rsp) begin
            r_pf_rd <= r_pf_rd + AW'(1);
         end
         if (bus.redirect_valid) begin
            // A response arriving now is part of the outstanding total, so it is dropped too.
            r_fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            r_drop     <= r_drop + r_inflight - CW'(w_rsp);
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
         end else begin
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_rsp && !w_rsp_drop);
            r_drop     <= r_drop - CW'(w_rsp_drop);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_pf[r_pf_wr] <= r_fetch_pc;
      end
      if (w_push) begin
         r_q_pc[r_wr_ptr]    <= r_pf[r_pf_rd];
         r_q_instr[r_wr_ptr] <= bus.imem_rsp_data;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed and stress bench for fetch_unit: cycle-exact vector tables, redirect
// corner sequences, a wrap-around RESET_PC instance and a random PC-stream check.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(32)) bus ();
   fetch_unit_if #(.XLEN(32)) bus2 ();

   fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      bit          start;
      int          lat;
      bit          rdy;
      bit          exp_rv;
      logic [31:0] exp_addr;
      bit          exp_ov;
      logic [31:0] exp_pc;
   } vec_t;

   mreq_t       memq[$];
   vec_t        vecs[$];
   int          nxt = 0;
   int          last_due = 0;
   int          mem_lat = 1;
   bit          mem_ready = 1'b1;
   bit          pend2 = 1'b0;
   logic [31:0] pend2_addr = '0;
   int          n_vec = 0;
   int          n_bad = 0;

   logic        s_req_valid, s_out_valid, s2_out_valid;
   logic [31:0] s_req_addr, s_out_pc, s_out_instr, s_plus4, s2_out_pc, s2_plus4;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_min(input string name, input int act, input int min_v);
      n_vec++;
      if (act < min_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected at least %0d", name, act, min_v);
      end
   endtask

   // One clock cycle: drive inputs after a negedge, run memory models, sample, advance.
   task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
      mreq_t m;
      bus.out_ready      = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.imem_req_ready = mem_ready;
      if (memq.size() > 0 && memq[0].due <= nxt) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = instr_of(memq[0].addr);
         void'(memq.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end
      bus2.imem_req_ready = 1'b1;
      bus2.out_ready      = 1'b1;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_pc    = '0;
      bus2.imem_rsp_valid = pend2;
      bus2.imem_rsp_data  = instr_of(pend2_addr);
      #1;
      s_req_valid  = bus.imem_req_valid;
      s_req_addr   = bus.imem_req_addr;
      s_out_valid  = bus.out_valid;
      s_out_pc     = bus.out_pc;
      s_out_instr  = bus.out_instr;
      s_plus4      = bus.out_pc_plus4;
      s2_out_valid = bus2.out_valid;
      s2_out_pc    = bus2.out_pc;
      s2_plus4     = bus2.out_pc_plus4;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         m.addr = bus.imem_req_addr;
         m.due  = (nxt + mem_lat > last_due + 1) ? nxt + mem_lat : last_due + 1;
         last_due = m.due;
         memq.push_back(m);
      end
      pend2      = bus2.imem_req_valid;
      pend2_addr = bus2.imem_req_addr;
      @(posedge clk);
      nxt++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      memq.delete();
      pend2    = 1'b0;
      last_due = 0;
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("reset.out_valid", 32'(s_out_valid), 32'h0);
      chk("reset.req_valid", 32'(s_req_valid), 32'h0);
      chk("reset.dut2_out_valid", 32'(s2_out_valid), 32'h0);
      reset = 1'b0;
   endtask

   // Run with out_ready high and require the consumed PCs to follow first, first+4, ...
   task automatic stream(input string tag, input logic [31:0] first, input int ncyc, input int min_cnt);
      logic [31:0] e;
      int          cnt;
      e   = first;
      cnt = 0;
      for (int i = 0; i < ncyc; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (s_out_valid) begin
            chk($sformatf("%s.pc%0d", tag, cnt), s_out_pc, e);
            chk($sformatf("%s.instr%0d", tag, cnt), s_out_instr, instr_of(e));
            chk($sformatf("%s.plus4_%0d", tag, cnt), s_plus4, e + 32'd4);
            e = e + 32'd4;
            cnt++;
         end
      end
      chk_min({tag, ".count"}, cnt, min_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] rpc;
      logic [31:0] d2_pc [3];
      logic [31:0] d2_p4 [3];
      int          cnt;
      bit          rdy, rv;

      // latency 1, decode always ready: one instruction per cycle
      vecs.push_back('{1, 1, 1, 1, 32'h00, 0, 32'h00});
      vecs.push_back('{0, 1, 1, 1, 32'h04, 0, 32'h00});
      vecs.push_back('{0, 1, 1, 1, 32'h08, 1, 32'h00});
      vecs.push_back('{0, 1, 1, 1, 32'h0C, 1, 32'h04});
      vecs.push_back('{0, 1, 1, 1, 32'h10, 1, 32'h08});
      vecs.push_back('{0, 1, 1, 1, 32'h14, 1, 32'h0C});
      vecs.push_back('{0, 1, 1, 1, 32'h18, 1, 32'h10});
      vecs.push_back('{0, 1, 1, 1, 32'h1C, 1, 32'h14});
      // latency 3, decode stalled: four requests then stall, then drain and resume
      vecs.push_back('{1, 3, 0, 1, 32'h00, 0, 32'h00});
      vecs.push_back('{0, 3, 0, 1, 32'h04, 0, 32'h00});
      vecs.push_back('{0, 3, 0, 1, 32'h08, 0, 32'h00});
      vecs.push_back('{0, 3, 0, 1, 32'h0C, 0, 32'h00});
      vecs.push_back('{0, 3, 0, 0, 32'h00, 1, 32'h00});
      vecs.push_back('{0, 3, 0, 0, 32'h00, 1, 32'h00});
      vecs.push_back('{0, 3, 0, 0, 32'h00, 1, 32'h00});
      vecs.push_back('{0, 3, 0, 0, 32'h00, 1, 32'h00});
      vecs.push_back('{0, 3, 1, 0, 32'h00, 1, 32'h00});
      vecs.push_back('{0, 3, 1, 1, 32'h10, 1, 32'h04});
      vecs.push_back('{0, 3, 1, 1, 32'h14, 1, 32'h08});
      vecs.push_back('{0, 3, 1, 1, 32'h18, 1, 32'h0C});
      vecs.push_back('{0, 3, 1, 1, 32'h1C, 0, 32'h00});
      vecs.push_back('{0, 3, 1, 0, 32'h00, 1, 32'h10});

      d2_pc[0] = 32'hFFFF_FFF8; d2_p4[0] = 32'hFFFF_FFFC;
      d2_pc[1] = 32'hFFFF_FFFC; d2_p4[1] = 32'h0000_0000;
      d2_pc[2] = 32'h0000_0000; d2_p4[2] = 32'h0000_0004;

      reset = 1'b1;
      bus.out_ready = 1'b0;      bus.redirect_valid = 1'b0;  bus.redirect_pc = '0;
      bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0;  bus.imem_rsp_data = '0;
      bus2.out_ready = 1'b1;     bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0;
      bus2.imem_req_ready = 1'b1; bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = '0;
      @(negedge clk);

      foreach (vecs[i]) begin
         if (vecs[i].start) begin
            mem_lat = vecs[i].lat;
            do_reset();
         end
         step(vecs[i].rdy, 1'b0, 32'h0);
         chk($sformatf("vec%0d.req_valid", i), 32'(s_req_valid), 32'(vecs[i].exp_rv));
         if (vecs[i].exp_rv) chk($sformatf("vec%0d.req_addr", i), s_req_addr, vecs[i].exp_addr);
         chk($sformatf("vec%0d.out_valid", i), 32'(s_out_valid), 32'(vecs[i].exp_ov));
         if (vecs[i].exp_ov) begin
            chk($sformatf("vec%0d.out_pc", i), s_out_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d.out_instr", i), s_out_instr, instr_of(vecs[i].exp_pc));
            chk($sformatf("vec%0d.plus4", i), s_plus4, vecs[i].exp_pc + 32'd4);
         end
      end

      // redirect to 0x103 with three requests in flight (latency 4)
      mem_lat = 4;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h0);
         chk($sformatf("redirA.req_addr%0d", i), s_req_addr, 32'(4 * i));
      end
      step(1'b1, 1'b1, 32'h0000_0103);
      chk("redirA.req_valid_in_redirect", 32'(s_req_valid), 32'h0);
      step(1'b1, 1'b0, 32'h0);
      chk("redirA.target_req_valid", 32'(s_req_valid), 32'h1);
      chk("redirA.target_req_addr", s_req_addr, 32'h0000_0100);
      chk("redirA.out_valid_after", 32'(s_out_valid), 32'h0);
      stream("redirA", 32'h0000_0100, 20, 6);

      // redirect coinciding with a response and a decode pop (latency 1)
      mem_lat = 1;
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h0000_0200);
      chk("redirB.head_valid", 32'(s_out_valid), 32'h1);
      chk("redirB.head_pc", s_out_pc, 32'h0000_0008);
      chk("redirB.req_valid_in_redirect", 32'(s_req_valid), 32'h0);
      step(1'b1, 1'b0, 32'h0);
      chk("redirB.out_valid_after", 32'(s_out_valid), 32'h0);
      chk("redirB.target_req_addr", s_req_addr, 32'h0000_0200);
      stream("redirB", 32'h0000_0200, 14, 8);

      // PC wrap-around on the RESET_PC = 0xFFFFFFF8 instance
      do_reset();
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (s2_out_valid && cnt < 3) begin
            chk($sformatf("wrap.pc%0d", cnt), s2_out_pc, d2_pc[cnt]);
            chk($sformatf("wrap.plus4_%0d", cnt), s2_plus4, d2_p4[cnt]);
            cnt++;
         end
      end
      chk_min("wrap.count", cnt, 3);

      // random ready/latency/redirect stress against a next-PC reference
      mem_lat = 1;
      do_reset();
      exp_pc = 32'h0;
      cnt    = 0;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            mem_ready = 1'b1;
            do_reset();
            exp_pc = 32'h0;
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         mem_lat   = int'($urandom_range(1, 4));
         rdy       = 1'($urandom_range(0, 1));
         rv        = ($urandom_range(0, 24) == 0);
         rpc       = $urandom();
         step(rdy, rv, rpc);
         if (rv) begin
            exp_pc = rpc & 32'hFFFF_FFFC;
         end else if (s_out_valid && rdy) begin
            chk($sformatf("stress.pc%0d", cnt), s_out_pc, exp_pc);
            chk($sformatf("stress.instr%0d", cnt), s_out_instr, instr_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            cnt++;
         end
         n_vec++;
         if (memq.size() > 4) begin
            n_bad++;
            $display("FAIL stress.outstanding: got %0d, expected at most 4", memq.size());
         end
      end
      chk_min("stress.consumed", cnt, 40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
